// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_bridge
//  Purpose  : Converts strobe-based, byte-addressed data-memory requests into
//             beats on a 64-bit doubleword-aligned req/ack memory bus.
//             Handles lane steering, byte enables and right-justified
//             read-data alignment.
//  Options  : DMEM_BRIDGE_SPLIT_EN - when defined, doubleword-crossing
//             accesses are split into two bus beats; when undefined they are
//             rejected with a fault pulse and no bus traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_bridge #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [63:0]       dmem_dout,
    input  logic [1:0]        dmem_width,
    input  logic              dmem_rstrobe,
    input  logic              dmem_wstrobe,
    output logic [63:0]       dmem_din,
    output logic              dmem_cycle_complete,
    output logic              dmem_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-4:0] mem_addr,
    output logic [7:0]        mem_be,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [ADDR_W-4:0] C_DW_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ0 = 2'd1,
`ifdef DMEM_BRIDGE_SPLIT_EN
        S_REQ1 = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    // Byte mask of an access of the given size, right-justified.
    function automatic logic [7:0] size_mask(input logic [1:0] width);
        case (width)
            2'd0:    size_mask = 8'hFF;
            2'd1:    size_mask = 8'h0F;
            2'd2:    size_mask = 8'h03;
            default: size_mask = 8'h01;
        endcase
    endfunction

    // Lanes touched in the first doubleword.
    function automatic logic [7:0] be_lo(input logic [2:0] off, input logic [1:0] width);
        be_lo = size_mask(width) << off;
    endfunction

    // Lanes spilling into the following doubleword (zero when off == 0).
    function automatic logic [7:0] be_hi(input logic [2:0] off, input logic [1:0] width);
        be_hi = size_mask(width) >> (4'd8 - {1'b0, off});
    endfunction

    // Read data: bytes off.. of {hi,lo}, bytes beyond the access size cleared.
    function automatic logic [63:0] align_rd(input logic [63:0] hi, input logic [63:0] lo,
                                             input logic [2:0] off, input logic [1:0] width);
        logic [6:0]  sh;
        logic [7:0]  m;
        logic [63:0] keep;
        sh = {1'b0, off, 3'b000};
        m  = size_mask(width);
        for (int i = 0; i < 8; i++) begin
            keep[8*i +: 8] = {8{m[i]}};
        end
        align_rd = ((lo >> sh) | (hi << (7'd64 - sh))) & keep;
    endfunction

`ifdef DMEM_BRIDGE_SPLIT_EN
    // Upper half of the 128-bit lane-steered store data (zero when off == 0).
    function automatic logic [63:0] wdata_hi(input logic [63:0] d, input logic [2:0] off);
        wdata_hi = d >> (7'd64 - {1'b0, off, 3'b000});
    endfunction
`endif

    state_t              state_q, state_d;
    logic [2:0]          off_q, off_d;
    logic [1:0]          width_q, width_d;
    logic                we_q, we_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-4:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_be_q, mem_be_d;
    logic [63:0]         mem_wdata_q, mem_wdata_d;
    logic [63:0]         din_q, din_d;
    logic                complete_q, complete_d;
`ifdef DMEM_BRIDGE_SPLIT_EN
    logic [63:0]         data_q, data_d;
    logic [63:0]         rd0_q, rd0_d;
`else
    logic                fault_q, fault_d;
    logic                w_in_cross;
`endif

    logic                w_strobe;
    logic [7:0]          w_in_be;
    logic [63:0]         w_in_wdata;

    // Beat-0 lane signals come straight from the request so the bus can be
    // driven in the cycle after the strobe.
    assign w_strobe   = dmem_rstrobe | dmem_wstrobe;
    assign w_in_be    = be_lo(dmem_addr[2:0], dmem_width);
    assign w_in_wdata = dmem_dout << {dmem_addr[2:0], 3'b000};
`ifndef DMEM_BRIDGE_SPLIT_EN
    assign w_in_cross = |be_hi(dmem_addr[2:0], dmem_width);
`endif

    // Next-state and next-output computation; outputs are registered.
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        width_d     = width_q;
        we_d        = we_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        din_d       = din_q;
        complete_d  = 1'b0;
`ifdef DMEM_BRIDGE_SPLIT_EN
        data_d      = data_q;
        rd0_d       = rd0_q;
`else
        fault_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_strobe) begin
                    off_d   = dmem_addr[2:0];
                    width_d = dmem_width;
                    we_d    = dmem_wstrobe;   // write wins over a coincident read
`ifdef DMEM_BRIDGE_SPLIT_EN
                    data_d  = dmem_dout;
`else
                    if (w_in_cross) begin
                        state_d    = S_DONE;
                        complete_d = 1'b1;
                        fault_d    = 1'b1;
                    end else
`endif
                    begin
                        state_d     = S_REQ0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = dmem_wstrobe;
                        mem_addr_d  = dmem_addr[ADDR_W-1:3];
                        mem_be_d    = w_in_be;
                        mem_wdata_d = dmem_wstrobe ? w_in_wdata : 64'd0;
                    end
                end
            end
            S_REQ0: begin
                if (mem_ack) begin
`ifdef DMEM_BRIDGE_SPLIT_EN
                    rd0_d = mem_rdata;
                    if (|be_hi(off_q, width_q)) begin
                        state_d     = S_REQ1;
                        mem_addr_d  = mem_addr_q + C_DW_ONE;
                        mem_be_d    = be_hi(off_q, width_q);
                        mem_wdata_d = we_q ? wdata_hi(data_q, off_q) : 64'd0;
                    end else
`endif
                    begin
                        state_d     = S_DONE;
                        mem_req_d   = 1'b0;
                        mem_we_d    = 1'b0;
                        mem_be_d    = 8'd0;
                        mem_wdata_d = 64'd0;
                        complete_d  = 1'b1;
                        if (!we_q) begin
                            din_d = align_rd(64'd0, mem_rdata, off_q, width_q);
                        end
                    end
                end
            end
`ifdef DMEM_BRIDGE_SPLIT_EN
            S_REQ1: begin
                if (mem_ack) begin
                    state_d     = S_DONE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 8'd0;
                    mem_wdata_d = 64'd0;
                    complete_d  = 1'b1;
                    if (!we_q) begin
                        din_d = align_rd(mem_rdata, rd0_q, off_q, width_q);
                    end
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            off_q       <= 3'd0;
            width_q     <= 2'd0;
            we_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 8'd0;
            mem_wdata_q <= 64'd0;
            din_q       <= 64'd0;
            complete_q  <= 1'b0;
`ifdef DMEM_BRIDGE_SPLIT_EN
            data_q      <= 64'd0;
            rd0_q       <= 64'd0;
`else
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            width_q     <= width_d;
            we_q        <= we_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            din_q       <= din_d;
            complete_q  <= complete_d;
`ifdef DMEM_BRIDGE_SPLIT_EN
            data_q      <= data_d;
            rd0_q       <= rd0_d;
`else
            fault_q     <= fault_d;
`endif
        end
    end

    assign mem_req             = mem_req_q;
    assign mem_we              = mem_we_q;
    assign mem_addr            = mem_addr_q;
    assign mem_be              = mem_be_q;
    assign mem_wdata           = mem_wdata_q;
    assign dmem_din            = din_q;
    assign dmem_cycle_complete = complete_q;
`ifdef DMEM_BRIDGE_SPLIT_EN
    assign dmem_fault          = 1'b0;
`else
    assign dmem_fault          = fault_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_bridge
//  Purpose  : Scoreboard bench for dmem_bridge. Stimulus pushes expected bus
//             beats and completions; a monitor compares them as they appear.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_bridge;

    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] dmem_addr = '0;
    logic [63:0]       dmem_dout = '0;
    logic [1:0]        dmem_width = '0;
    logic              dmem_rstrobe = 1'b0;
    logic              dmem_wstrobe = 1'b0;
    logic [63:0]       dmem_din;
    logic              dmem_cycle_complete;
    logic              dmem_fault;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-4:0] mem_addr;
    logic [7:0]        mem_be;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata = '0;
    logic              mem_ack = 1'b0;

    dmem_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .dmem_addr           (dmem_addr),
        .dmem_dout           (dmem_dout),
        .dmem_width          (dmem_width),
        .dmem_rstrobe        (dmem_rstrobe),
        .dmem_wstrobe        (dmem_wstrobe),
        .dmem_din            (dmem_din),
        .dmem_cycle_complete (dmem_cycle_complete),
        .dmem_fault          (dmem_fault),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_be              (mem_be),
        .mem_wdata           (mem_wdata),
        .mem_rdata           (mem_rdata),
        .mem_ack             (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-4:0] addr;
        logic [7:0]        be;
        logic [63:0]       wdata;
    } beat_t;

    typedef struct {
        logic [63:0] din;
        logic        fault;
        int          cyc;
    } comp_t;

    beat_t       exp_beats[$];
    comp_t       exp_comps[$];
    logic [63:0] rdata_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          ack_wait = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic we, input logic [ADDR_W-4:0] a,
                             input logic [7:0] be, input logic [63:0] wd);
        beat_t b;
        b.we = we; b.addr = a; b.be = be; b.wdata = wd;
        exp_beats.push_back(b);
    endtask

    // Issue one request and wait (bounded) for its completion.
    task automatic issue(input logic w, input logic r, input logic [63:0] a,
                         input logic [1:0] wd, input logic [63:0] d, input int waitc,
                         input logic [63:0] exp_din, input logic exp_fault,
                         input int lat, input bit poke);
        comp_t c;
        ack_wait = waitc;
        @(negedge clk);
        c.din = exp_din; c.fault = exp_fault; c.cyc = cyc + lat;
        exp_comps.push_back(c);
        dmem_addr = a; dmem_width = wd; dmem_dout = d;
        dmem_wstrobe = w; dmem_rstrobe = r;
        @(negedge clk);
        dmem_wstrobe = 1'b0; dmem_rstrobe = 1'b0;
        dmem_addr = '0; dmem_dout = '0;
        if (poke) begin
            // A strobe while busy must not start another transaction.
            @(negedge clk);
            dmem_addr = 64'h50; dmem_width = 2'd3; dmem_dout = 64'hEE; dmem_wstrobe = 1'b1;
            @(negedge clk);
            dmem_wstrobe = 1'b0;
        end
        for (int i = 0; i < 100 && exp_comps.size() != 0; i++) @(negedge clk);
        if (exp_comps.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL completion_timeout: got no completion expected one at cycle %0d", c.cyc);
            exp_comps.delete(); exp_beats.delete(); rdata_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Bus responder: acks after ack_wait cycles of mem_req, read data from rdata_q.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (wcnt >= ack_wait) begin
                    mem_ack = 1'b1;
                    if (rdata_q.size() > 0) mem_rdata = rdata_q.pop_front();
                    else mem_rdata = 64'd0;
                    wcnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: compares bus beats and completions against the queues.
    initial begin
        beat_t b;
        comp_t c;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (mem_req) begin
                    if (exp_beats.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_req: got mem_req=1 addr=%0h expected no request", mem_addr);
                    end else begin
                        b = exp_beats[0];
                        check("bus_beat", {mem_we, mem_addr, mem_be, mem_wdata},
                              {b.we, b.addr, b.be, b.wdata});
                        if (mem_ack) void'(exp_beats.pop_front());
                    end
                end
                if (dmem_cycle_complete) begin
                    if (exp_comps.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_complete: got complete at cycle %0d expected none", cyc);
                    end else begin
                        c = exp_comps.pop_front();
                        check("dmem_din", dmem_din, c.din);
                        check("dmem_fault", dmem_fault, c.fault);
                        check("complete_cycle", cyc, c.cyc);
                        check("req_low_at_complete", mem_req, 1'b0);
                    end
                end else if (dmem_fault) begin
                    n_checks++; n_errors++;
                    $display("FAIL lone_fault: got fault without complete expected none");
                end
            end
        end
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {dmem_din, dmem_cycle_complete, dmem_fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata},
              '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Aligned 64b read, zero-wait ack.
        push_beat(1'b0, 61'h200, 8'hFF, 64'd0);
        rdata_q.push_back(64'h1122334455667788);
        issue(1'b0, 1'b1, 64'h1000, 2'd0, 64'd0, 0, 64'h1122334455667788, 1'b0, 2, 1'b0);

        // 8b write to lane 5; din keeps the last read value.
        push_beat(1'b1, 61'h200, 8'h20, 64'h0000AB0000000000);
        issue(1'b1, 1'b0, 64'h1005, 2'd3, 64'hAB, 0, 64'h1122334455667788, 1'b0, 2, 1'b0);

        // 16b read at offset 3, ack after 3 waits: lanes 3,4 hold 0x99,0xAA.
        push_beat(1'b0, 61'h400, 8'h18, 64'd0);
        rdata_q.push_back(64'hDDCCBBAA99887766);
        issue(1'b0, 1'b1, 64'h2003, 2'd2, 64'd0, 3, 64'h000000000000AA99, 1'b0, 5, 1'b1);

        // Coincident read and write strobes: the write is performed.
        push_beat(1'b1, 61'h2, 8'h01, 64'h5A);
        issue(1'b1, 1'b1, 64'h10, 2'd3, 64'h5A, 0, 64'h000000000000AA99, 1'b0, 2, 1'b0);

        // 32b write ending exactly on the doubleword boundary.
        push_beat(1'b1, 61'h600, 8'hF0, 64'hA1B2C3D400000000);
        issue(1'b1, 1'b0, 64'h3004, 2'd1, 64'hA1B2C3D4, 0, 64'h000000000000AA99, 1'b0, 2, 1'b0);

        // 8b read from the top lane.
        push_beat(1'b0, 61'h0, 8'h80, 64'd0);
        rdata_q.push_back(64'h8877665544332211);
        issue(1'b0, 1'b1, 64'h7, 2'd3, 64'd0, 0, 64'h88, 1'b0, 2, 1'b0);

        // 64b read at the highest doubleword, one wait cycle.
        push_beat(1'b0, 61'h1FFFFFFFFFFFFFFF, 8'hFF, 64'd0);
        rdata_q.push_back(64'h0123456789ABCDEF);
        issue(1'b0, 1'b1, 64'hFFFFFFFFFFFFFFF8, 2'd0, 64'd0, 1, 64'h0123456789ABCDEF, 1'b0, 3, 1'b0);

`ifdef DMEM_BRIDGE_SPLIT_EN
        // Split 32b write across 0x600/0x601.
        push_beat(1'b1, 61'h600, 8'hC0, 64'hC3D4000000000000);
        push_beat(1'b1, 61'h601, 8'h03, 64'h000000000000A1B2);
        issue(1'b1, 1'b0, 64'h3006, 2'd1, 64'hA1B2C3D4, 0, 64'h0123456789ABCDEF, 1'b0, 3, 1'b0);

        // Split 64b read.
        push_beat(1'b0, 61'h800, 8'hF0, 64'd0);
        push_beat(1'b0, 61'h801, 8'h0F, 64'd0);
        rdata_q.push_back(64'h8877665544332211);
        rdata_q.push_back(64'h00000000CCBBAA99);
        issue(1'b0, 1'b1, 64'h4004, 2'd0, 64'd0, 0, 64'hCCBBAA9988776655, 1'b0, 3, 1'b0);

        // Split 16b read wrapping the doubleword address to zero.
        push_beat(1'b0, 61'h1FFFFFFFFFFFFFFF, 8'h80, 64'd0);
        push_beat(1'b0, 61'h0, 8'h01, 64'd0);
        rdata_q.push_back(64'h1100000000000000);
        rdata_q.push_back(64'h0000000000000022);
        issue(1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 2'd2, 64'd0, 0, 64'h2211, 1'b0, 3, 1'b0);
`else
        // Crossing accesses are rejected without bus traffic.
        issue(1'b0, 1'b1, 64'h4004, 2'd0, 64'd0, 0, 64'h0123456789ABCDEF, 1'b1, 1, 1'b0);
        issue(1'b0, 1'b1, 64'h7, 2'd2, 64'd0, 0, 64'h0123456789ABCDEF, 1'b1, 1, 1'b0);
        issue(1'b1, 1'b0, 64'h3006, 2'd1, 64'hA1B2C3D4, 0, 64'h0123456789ABCDEF, 1'b1, 1, 1'b0);
`endif

        // Reset while a beat is pending: request drops at once, no completion.
        ack_wait = 50;
        push_beat(1'b0, 61'h400, 8'h18, 64'd0);
        @(negedge clk);
        dmem_addr = 64'h2003; dmem_width = 2'd2; dmem_rstrobe = 1'b1;
        @(negedge clk);
        dmem_rstrobe = 1'b0; dmem_addr = '0;
        repeat (2) @(negedge clk);
        check("req_before_reset", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_drops_req", mem_req, 1'b0);
        check("reset_no_complete", dmem_cycle_complete, 1'b0);
        check("reset_clears_din", dmem_din, 64'd0);
        exp_beats.delete(); rdata_q.delete(); ack_wait = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Next access after reset behaves normally.
        push_beat(1'b0, 61'h400, 8'hF0, 64'd0);
        rdata_q.push_back(64'hDDCCBBAA99887766);
        issue(1'b0, 1'b1, 64'h2004, 2'd1, 64'd0, 0, 64'h00000000DDCCBBAA, 1'b0, 2, 1'b0);

        check("beats_drained", exp_beats.size(), 0);
        check("comps_drained", exp_comps.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
